kamus_ex_muldiv: RTL and testbench
==================================

Name: kamus_ex_muldiv

Overview:
Parametrised multi-cycle RV32M execute unit that sits beside the single-cycle EX ALU in the kamus core. It computes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU with an iterative shift-add / restoring-division datapath that retires RADIX_BITS bits per cycle. While it works, it holds the ID-EX stage in a stall. It returns the result with a one-cycle valid pulse and the destination register address, ready for the EX-MEM interface.

Parameters:
XLEN, 32, operand/result width; must be a multiple of RADIX_BITS
RADIX_BITS, 1, bits processed per iteration (1, 2 or 4); iteration count N = XLEN/RADIX_BITS

Ports:
clk_i  in  1  core clock
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  request a new operation (from ID-EX)
op_i  in  3  muldiv_op_e operation select
rs1_data_i  in  XLEN  operand A (multiplicand / dividend)
rs2_data_i  in  XLEN  operand B (multiplier / divisor)
rd_addr_i  in  5  destination register
flush_i  in  1  kill in-flight operation (branch taken / trap)
busy_o  out  1  stall request to ID-EX
valid_o  out  1  one-cycle pulse, result_o/rd_addr_o valid
result_o  out  XLEN  result
rd_addr_o  out  5  destination of result_o

Behaviour:
- Reset (async, rst_ni=0): state=IDLE; busy_o=0, valid_o=0, result_o=0, rd_addr_o=0; all internal accumulators cleared. Reset mid-operation abandons it with no valid_o.
- FSM states: IDLE, CALC, DONE.
- Accept: start_i=1 && flush_i=0 in IDLE or DONE. Operands, op and rd are registered at the accepting edge (cycle 0). start_i in CALC is ignored; the caller holds it under busy_o.
- Transitions after accept:
  - Special case → DONE at cycle 1.
  - Otherwise → CALC for cycles 1..N, then DONE at cycle N+1.
  - DONE → IDLE next cycle, unless a new accept occurs (back-to-back allowed).
- busy_o is combinational: high in the accepting cycle and throughout CALC; low in DONE and IDLE.
- valid_o=1 only in DONE. result_o and rd_addr_o are registered on entry to DONE and held until the next DONE.
- Operand prep at accept:
  - Signed ops (MULH, DIV, REM; rs1 only for MULHSU) take absolute values and record result sign.
  - MUL low word is sign-agnostic.
- Multiply: 2*XLEN product accumulator, RADIX_BITS multiplier bits per cycle. Final negate if sign set. MUL returns the low word; MULH* return the high word.
- Divide: restoring division, RADIX_BITS quotient bits per cycle.
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
- Special cases (1-cycle path, no iteration):
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → dividend.
  - Signed overflow (-2^(XLEN-1) / -1): DIV → -2^(XLEN-1); REM → 0.
- flush_i: in CALC, return to IDLE next edge with no valid_o and busy_o low. flush_i in the accept cycle blocks the accept. flush_i in DONE does not suppress that valid_o; the pipeline discards it.
- All arithmetic is unsigned internally at XLEN+1 / 2*XLEN widths; no X propagation on unused ops (default result 0).

Decomposition:
- kamus_pkg holds:
  - muldiv_op_e: MUL=0, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - mdu_state_e: IDLE, CALC, DONE.
- One combinational sub-module, kamus_mdu_step. Inputs: accumulator, operand, mode. Output: the next accumulator after one RADIX_BITS step. Instantiated once and reused each cycle.

Test Plan:
- MUL 7 × 0xFFFFFFFD, RADIX_BITS=1, start at cycle 0 → busy_o high cycles 0..32; valid_o at cycle 33, result 0xFFFFFFEB, rd_addr_o echoed.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU same operands → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. RADIX_BITS=4: valid at cycle 9.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIV by 0 → 0xFFFFFFFF and REM by 0 → dividend, both valid at cycle 1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, both at cycle 1.
- flush_i at cycle 10 of a DIV → no valid_o, busy_o low from cycle 11. A new start at cycle 12 completes normally. rst_ni pulse mid-CALC → all outputs 0 immediately.
- start_i held during DONE of op A → op B accepted that cycle; A's valid_o seen once; B's result follows N+1 cycles later.

Source files
------------

// File: rtl/kamus_pkg.sv
// Shared types for the kamus RV32M multi-cycle execute unit.
package kamus_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

endpackage

// File: rtl/kamus_mdu_step.sv
// One RADIX_BITS iteration of shift-add multiply or restoring divide.
module kamus_mdu_step
  import kamus_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  step_mode_e        mode,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN+RADIX_BITS-1:0] sum;
  logic [XLEN:0]              rem;
  logic [XLEN-1:0]            quo;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    sum      = '0;
    rem      = '0;
    quo      = '0;
    acc_next = '0;
    if (mode == STEP_DIV) begin
      rem = {1'b0, acc[2*XLEN-1:XLEN]};
      quo = acc[XLEN-1:0];
      for (int unsigned i = 0; i < RADIX_BITS; i++) begin
        rem = {rem[XLEN-1:0], quo[XLEN-1]};
        quo = {quo[XLEN-2:0], 1'b0};
        if (rem >= {1'b0, operand}) begin
          rem    = rem - {1'b0, operand};
          quo[0] = 1'b1;
        end
      end
      acc_next = {rem[XLEN-1:0], quo};
    end else begin
      sum = {{RADIX_BITS{1'b0}}, acc[2*XLEN-1:XLEN]}
          + ({{RADIX_BITS{1'b0}}, operand} * {{XLEN{1'b0}}, acc[RADIX_BITS-1:0]});
      acc_next = {sum, acc[XLEN-1:RADIX_BITS]};
    end
  end

endmodule

// File: rtl/kamus_ex_muldiv.sv
// Iterative RV32M multiply/divide unit; stalls ID-EX while busy, pulses valid on completion.
module kamus_ex_muldiv
  import kamus_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  localparam int unsigned N  = XLEN / RADIX_BITS;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state, state_next;
  muldiv_op_e        op, op_in;
  logic [2*XLEN-1:0] acc, acc_next;
  logic [XLEN-1:0]   operand;
  logic              neg, neg_in;
  logic [CW-1:0]     cnt;
  logic [4:0]        rd_q;
  logic              accept, last, special;
  logic              sa, sb;
  logic [XLEN-1:0]   abs_a, abs_b, special_res, final_res, quo, rem;
  logic [2*XLEN-1:0] prod;

  assign op_in   = muldiv_op_e'(op_i);
  assign accept  = start_i && !flush_i && (state != CALC);
  assign last    = (cnt == '0);
  assign busy_o  = accept || (state == CALC);
  assign valid_o = (state == DONE);

  // Operand preparation: magnitudes, result sign and single-cycle special cases.
  always_comb begin
    sa          = 1'b0;
    sb          = 1'b0;
    neg_in      = 1'b0;
    special     = 1'b0;
    special_res = '0;
    case (op_in)
      MULH: begin
        sa     = rs1_data_i[XLEN-1];
        sb     = rs2_data_i[XLEN-1];
        neg_in = sa ^ sb;
      end
      MULHSU: begin
        sa     = rs1_data_i[XLEN-1];
        neg_in = sa;
      end
      DIV, REM: begin
        sa     = rs1_data_i[XLEN-1];
        sb     = rs2_data_i[XLEN-1];
        neg_in = (op_in == DIV) ? (sa ^ sb) : sa;
        if (rs2_data_i == '0) begin
          special     = 1'b1;
          special_res = (op_in == DIV) ? '1 : rs1_data_i;
        end else if (rs1_data_i == MIN_NEG && rs2_data_i == '1) begin
          special     = 1'b1;
          special_res = (op_in == DIV) ? MIN_NEG : '0;
        end
      end
      DIVU, REMU: begin
        if (rs2_data_i == '0) begin
          special     = 1'b1;
          special_res = (op_in == DIVU) ? '1 : rs1_data_i;
        end
      end
      default: ;
    endcase
    abs_a = sa ? -rs1_data_i : rs1_data_i;
    abs_b = sb ? -rs2_data_i : rs2_data_i;
  end

  kamus_mdu_step #(
    .XLEN       (XLEN),
    .RADIX_BITS (RADIX_BITS)
  ) u_step (
    .acc      (acc),
    .operand  (operand),
    .mode     (op[2] ? STEP_DIV : STEP_MUL),
    .acc_next (acc_next)
  );

  // Final sign fix applied to the last step's output so DONE holds the result.
  always_comb begin
    prod      = neg ? -acc_next : acc_next;
    quo       = neg ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem       = neg ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    final_res = '0;
    case (op)
      MUL:                 final_res = acc_next[XLEN-1:0];
      MULH, MULHSU, MULHU: final_res = prod[2*XLEN-1:XLEN];
      DIV, DIVU:           final_res = quo;
      REM, REMU:           final_res = rem;
      default:             final_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: begin
        if (flush_i)   state_next = IDLE;
        else if (last) state_next = DONE;
      end
      DONE: state_next = accept ? (special ? DONE : CALC) : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op        <= MUL;
      neg       <= 1'b0;
      acc       <= '0;
      operand   <= '0;
      cnt       <= '0;
      rd_q      <= '0;
      result_o  <= '0;
      rd_addr_o <= '0;
    end else if (accept) begin
      op      <= op_in;
      neg     <= neg_in;
      rd_q    <= rd_addr_i;
      cnt     <= CW'(N - 1);
      acc     <= {{XLEN{1'b0}}, op_in[2] ? abs_a : abs_b};
      operand <= op_in[2] ? abs_b : abs_a;
      if (special) begin
        result_o  <= special_res;
        rd_addr_o <= rd_addr_i;
      end
    end else if (state == CALC && !flush_i) begin
      acc <= acc_next;
      cnt <= cnt - CW'(1);
      if (last) begin
        result_o  <= final_res;
        rd_addr_o <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_kamus_ex_muldiv.sv
// Self-checking bench: radix-1 and radix-4 instances against an arithmetic reference model.
module tb_kamus_ex_muldiv;
  import kamus_pkg::*;

  logic        clk, rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        busy1, valid1, busy4, valid4;
  logic [31:0] res1, res4;
  logic [4:0]  rdo1, rdo4;
  int tests = 0;
  int fails = 0;

  kamus_ex_muldiv #(.XLEN(32), .RADIX_BITS(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .rs1_data_i(rs1),
    .rs2_data_i(rs2), .rd_addr_i(rd), .flush_i(flush), .busy_o(busy1),
    .valid_o(valid1), .result_o(res1), .rd_addr_o(rdo1)
  );

  kamus_ex_muldiv #(.XLEN(32), .RADIX_BITS(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .rs1_data_i(rs1),
    .rs2_data_i(rs2), .rd_addr_i(rd), .flush_i(flush), .busy_o(busy4),
    .valid_o(valid4), .result_o(res4), .rd_addr_o(rdo4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o < 3'd4) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (o == DIV || o == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      xa, xb, q, r;
    logic [63:0] p;
    bit          sga, sgb;
    sga = (o == MULH || o == MULHSU || o == DIV || o == REM);
    sgb = (o == MULH || o == DIV || o == REM);
    xa  = sga ? {{32{a[31]}}, a} : {32'd0, a};
    xb  = sgb ? {{32{b[31]}}, b} : {32'd0, b};
    if (o < 3'd4) begin
      p = xa * xb;
      return (o == MUL) ? p[31:0] : p[63:32];
    end
    if (b == 32'd0) return (o == DIV || o == DIVU) ? 32'hFFFF_FFFF : a;
    q = xa / xb;
    r = xa % xb;
    return (o == DIV || o == DIVU) ? q[31:0] : r[31:0];
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input string tag);
    logic [31:0] e, r1, r4;
    logic [4:0]  d1, d4;
    int lat1, lat4, first1, first4, n1, n4, bad1, bad4;
    e    = ref_result(o, a, b);
    lat1 = ref_special(o, a, b) ? 1 : 33;
    lat4 = ref_special(o, a, b) ? 1 : 9;
    first1 = -1; first4 = -1; n1 = 0; n4 = 0; bad1 = 0; bad4 = 0;
    r1 = '0; r4 = '0; d1 = '0; d4 = '0;
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; rd = d; start = 1'b1;
    for (int c = 0; c <= 36; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) begin
        start = 1'b0; rs1 = $urandom; rs2 = $urandom; rd = 5'($urandom); op = 3'($urandom);
      end
      #1;
      if (valid1) begin n1++; if (first1 < 0) begin first1 = c; r1 = res1; d1 = rdo1; end end
      if (valid4) begin n4++; if (first4 < 0) begin first4 = c; r4 = res4; d4 = rdo4; end end
      if (busy1 !== (c < lat1)) bad1++;
      if (busy4 !== (c < lat4)) bad4++;
    end
    check({tag, "/lat_r1"},   32'(first1), 32'(lat1));
    check({tag, "/lat_r4"},   32'(first4), 32'(lat4));
    check({tag, "/res_r1"},   r1, e);
    check({tag, "/res_r4"},   r4, e);
    check({tag, "/rd_r1"},    32'(d1), 32'(d));
    check({tag, "/rd_r4"},    32'(d4), 32'(d));
    check({tag, "/nvalid_r1"}, 32'(n1), 32'd1);
    check({tag, "/nvalid_r4"}, 32'(n4), 32'd1);
    check({tag, "/busy_r1"},  32'(bad1), 32'd0);
    check({tag, "/busy_r4"},  32'(bad4), 32'd0);
  endtask

  initial begin
    int first, nv, t1, t2;
    logic [31:0] r, ra, rb2, rtwo;
    logic [4:0] da, db;
    logic b11, b33;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset/busy",  32'(busy1),  32'd0);
    check("reset/valid", 32'(valid1), 32'd0);
    check("reset/res",   res1,        32'd0);
    check("reset/rd",    32'(rdo1),   32'd0);
    check("reset/res4",  res4,        32'd0);
    rst_n = 1'b1;

    run_op(MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  "mul");
    run_op(MULH,   32'h8000_0000,  32'h8000_0000, 5'd6,  "mulh");
    run_op(MULHU,  32'h8000_0000,  32'h8000_0000, 5'd7,  "mulhu");
    run_op(MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  "mulhsu");
    run_op(DIV,    32'hFFFF_FFF9,  32'd2,         5'd9,  "div");
    run_op(REM,    32'hFFFF_FFF9,  32'd2,         5'd10, "rem");
    run_op(DIVU,   32'd100,        32'd7,         5'd11, "divu");
    run_op(REMU,   32'd100,        32'd7,         5'd12, "remu");
    run_op(DIV,    32'h1234_5678,  32'd0,         5'd13, "div0");
    run_op(REM,    32'h1234_5678,  32'd0,         5'd14, "rem0");
    run_op(DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, "divovf");
    run_op(REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, "removf");

    for (int i = 0; i < 20; i++) begin
      logic [2:0]  ro;
      logic [31:0] xa, xb;
      int unsigned sel;
      ro = 3'($urandom); xa = $urandom; xb = $urandom; sel = $urandom_range(0, 5);
      if (sel == 0)      xb = 32'($urandom_range(1, 15));
      else if (sel == 1) xb = '0;
      else if (sel == 2) begin
        xa = 32'h8000_0000;
        if ($urandom_range(0, 1) == 0) xb = 32'hFFFF_FFFF;
      end
      run_op(ro, xa, xb, 5'($urandom), "rand");
    end

    // Flush mid-DIV, then a fresh accept two cycles later.
    first = -1; nv = 0; r = '0; b11 = 1'bx;
    @(negedge clk);
    op = DIV; rs1 = 32'd1000; rs2 = 32'd3; rd = 5'd9; start = 1'b1;
    for (int c = 0; c <= 50; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1)  start = 1'b0;
      if (c == 10) flush = 1'b1;
      if (c == 11) flush = 1'b0;
      if (c == 12) begin op = DIVU; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd12; start = 1'b1; end
      if (c == 13) start = 1'b0;
      #1;
      if (c == 11) b11 = busy1;
      if (valid1) begin nv++; if (first < 0) begin first = c; r = res1; end end
    end
    check("flush/busy_c11", 32'(b11),   32'd0);
    check("flush/nvalid",   32'(nv),    32'd1);
    check("flush/lat",      32'(first), 32'd45);
    check("flush/res",      r,          32'd14);

    // Reset pulse while both instances are in CALC.
    nv = 0;
    @(negedge clk);
    op = MUL; rs1 = 32'd123; rs2 = 32'd456; rd = 5'd3; start = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 5) rst_n = 1'b0;
      if (c == 6) rst_n = 1'b1;
      #1;
      if (c == 5) begin
        check("rstmid/busy",  32'(busy1),  32'd0);
        check("rstmid/valid", 32'(valid1), 32'd0);
        check("rstmid/res",   res1,        32'd0);
        check("rstmid/rd",    32'(rdo1),   32'd0);
        check("rstmid/busy4", 32'(busy4),  32'd0);
      end
      if (c >= 5 && (valid1 || valid4)) nv++;
    end
    check("rstmid/nvalid", 32'(nv), 32'd0);

    // Back-to-back: B accepted in A's DONE cycle on the radix-1 instance.
    nv = 0; t1 = -1; t2 = -1; ra = '0; rb2 = '0; da = '0; db = '0; b33 = 1'bx;
    rtwo = ref_result(DIVU, 32'd1000, 32'd7);
    @(negedge clk);
    op = MULHU; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; rd = 5'd21; start = 1'b1;
    for (int c = 0; c <= 70; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1)  start = 1'b0;
      if (c == 33) begin op = DIVU; rs1 = 32'd1000; rs2 = 32'd7; rd = 5'd22; start = 1'b1; end
      if (c == 34) start = 1'b0;
      #1;
      if (c == 33) b33 = busy1;
      if (valid1) begin
        nv++;
        if (nv == 1) begin t1 = c; ra = res1; da = rdo1; end
        if (nv == 2) begin t2 = c; rb2 = res1; db = rdo1; end
      end
    end
    check("b2b/busy_c33", 32'(b33), 32'd1);
    check("b2b/nvalid",   32'(nv),  32'd2);
    check("b2b/lat_a",    32'(t1),  32'd33);
    check("b2b/res_a",    ra,       ref_result(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    check("b2b/rd_a",     32'(da),  32'd21);
    check("b2b/lat_b",    32'(t2),  32'd66);
    check("b2b/res_b",    rb2,      rtwo);
    check("b2b/rd_b",     32'(db),  32'd22);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
